// File: rtl/cmp_arbiter.sv
// Two-requester round-robin front end for one shared 2-bit comparator (optional one-hot check: CMP_ARBITER_ONEHOT_CHECK_EN).
// Latency: a transfer in cycle T gives rsp_valid in cycle T+HOLD_CYCLES+1.
// Backpressure: requests are held off (no ready) until the result has been taken with rsp_ready.
module cmp_arbiter #(
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [1:0] req0_a,
    input  logic [1:0] req0_b,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [1:0] req1_a,
    input  logic [1:0] req1_b,
    output logic       req1_ready,
    output logic [1:0] cmp_in1,
    output logic [1:0] cmp_in2,
    input  logic       cmp_o1,
    input  logic       cmp_o2,
    input  logic       cmp_o3,
    output logic       rsp_valid,
    output logic       rsp_id,
    output logic [2:0] rsp_res,
    input  logic       rsp_ready,
    output logic       busy
`ifdef CMP_ARBITER_ONEHOT_CHECK_EN
    ,
    output logic       cmp_err
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(HOLD_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic       last_grant;
    logic       gnt0;
    logic       gnt1;
    logic       take;
    logic       capture;
    logic [2:0] cmp_res;

    // last_grant==1 means requester 1 won last time, so requester 0 wins a tie.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (req0_valid && req1_valid) begin
            gnt0 = last_grant;
            gnt1 = ~last_grant;
        end else begin
            gnt0 = req0_valid;
            gnt1 = req1_valid;
        end
    end

    assign req0_ready = rst_n && (state == IDLE) && gnt0;
    assign req1_ready = rst_n && (state == IDLE) && gnt1;
    assign take       = req0_ready | req1_ready;
    assign capture    = (state == SETTLE) && (cnt == 4'd0);
    assign cmp_res    = {cmp_o1, cmp_o2, cmp_o3};
    assign rsp_valid  = (state == RESP);
    assign busy       = (state != IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (take) state_nxt = SETTLE;
            SETTLE:  if (cnt == 4'd0) state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            last_grant <= 1'b1;
            cmp_in1    <= 2'b00;
            cmp_in2    <= 2'b00;
            rsp_id     <= 1'b0;
            rsp_res    <= 3'b000;
        end else begin
            state <= state_nxt;
            if (take) begin
                cmp_in1    <= req1_ready ? req1_a : req0_a;
                cmp_in2    <= req1_ready ? req1_b : req0_b;
                rsp_id     <= req1_ready;
                last_grant <= req1_ready;
                cnt        <= CNT_LOAD;
            end
            if (state == SETTLE) begin
                if (cnt == 4'd0) rsp_res <= cmp_res;
                else             cnt     <= cnt - 4'd1;
            end
        end
    end

`ifdef CMP_ARBITER_ONEHOT_CHECK_EN
    logic res_onehot;

    assign res_onehot = (cmp_res == 3'b100) || (cmp_res == 3'b010) || (cmp_res == 3'b001);

    // Sticky until reset so a single bad comparator result is never missed.
    always_ff @(posedge clk) begin
        if (!rst_n)                       cmp_err <= 1'b0;
        else if (capture && !res_onehot)  cmp_err <= 1'b1;
    end
`else
    logic unused_capture;
    assign unused_capture = capture;
`endif

endmodule

// File: tb/tb_cmp_arbiter.sv
// Scoreboard bench for cmp_arbiter: HOLD_CYCLES=1 instance for the main flow, HOLD_CYCLES=3 instance for backpressure.
module tb_cmp_arbiter;

    typedef struct {
        bit       id;
        bit [2:0] res;
        int       t;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A, HOLD_CYCLES=1
    logic       r0v = 0, r1v = 0, r0rdy, r1rdy, rsprdy = 1;
    logic [1:0] r0a = 0, r0b = 0, r1a = 0, r1b = 0, ci1, ci2;
    logic       o1, o2, o3, rspv, rspid, bsy;
    logic [2:0] rspres;
    bit         force_bad = 0;
`ifdef CMP_ARBITER_ONEHOT_CHECK_EN
    logic       cerr;
`endif

    // Instance B, HOLD_CYCLES=3
    logic       b_r0v = 0, b_r1v = 0, b_r0rdy, b_r1rdy, b_rsprdy = 0;
    logic [1:0] b_r0a = 0, b_r0b = 0, b_r1a = 0, b_r1b = 0, b_ci1, b_ci2;
    logic       b_o1, b_o2, b_o3, b_rspv, b_rspid, b_bsy;
    logic [2:0] b_rspres;
`ifdef CMP_ARBITER_ONEHOT_CHECK_EN
    logic       b_cerr;
`endif

    function automatic bit [2:0] golden(input bit [1:0] a, input bit [1:0] b);
        if (a > b)       return 3'b100;
        else if (a == b) return 3'b010;
        else             return 3'b001;
    endfunction

    always_comb {o1, o2, o3} = force_bad ? 3'b110 : golden(ci1, ci2);
    always_comb {b_o1, b_o2, b_o3} = golden(b_ci1, b_ci2);

    cmp_arbiter #(.HOLD_CYCLES(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r0v), .req0_a(r0a), .req0_b(r0b), .req0_ready(r0rdy),
        .req1_valid(r1v), .req1_a(r1a), .req1_b(r1b), .req1_ready(r1rdy),
        .cmp_in1(ci1), .cmp_in2(ci2), .cmp_o1(o1), .cmp_o2(o2), .cmp_o3(o3),
        .rsp_valid(rspv), .rsp_id(rspid), .rsp_res(rspres), .rsp_ready(rsprdy),
        .busy(bsy)
`ifdef CMP_ARBITER_ONEHOT_CHECK_EN
        , .cmp_err(cerr)
`endif
    );

    cmp_arbiter #(.HOLD_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(b_r0v), .req0_a(b_r0a), .req0_b(b_r0b), .req0_ready(b_r0rdy),
        .req1_valid(b_r1v), .req1_a(b_r1a), .req1_b(b_r1b), .req1_ready(b_r1rdy),
        .cmp_in1(b_ci1), .cmp_in2(b_ci2), .cmp_o1(b_o1), .cmp_o2(b_o2), .cmp_o3(b_o3),
        .rsp_valid(b_rspv), .rsp_id(b_rspid), .rsp_res(b_rspres), .rsp_ready(b_rsprdy),
        .busy(b_bsy)
`ifdef CMP_ARBITER_ONEHOT_CHECK_EN
        , .cmp_err(b_cerr)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    exp_t sb[$];

    // Monitor: compares every response of instance A against the scoreboard.
    logic       prev_v = 0, prev_r = 0, prev_id = 0;
    logic [2:0] prev_res = 0;
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            prev_v = 0;
        end else begin
            if (rspv && !prev_v) begin
                if (sb.size() == 0) chk("unexpected_rsp", 1, 0);
                else                chk("latency", cyc, sb[0].t + 2);
            end
            if (rspv && prev_v && !prev_r) begin
                chk("hold_id", rspid, prev_id);
                chk("hold_res", rspres, prev_res);
            end
            if (rspv && rsprdy && sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_id", rspid, e.id);
                chk("rsp_res", rspres, e.res);
            end
            prev_v = rspv; prev_r = rsprdy; prev_id = rspid; prev_res = rspres;
        end
    end

    // Called just after a negedge; returns at the following negedge after the transfer.
    task automatic send(input bit id, input bit [1:0] a, input bit [1:0] b,
                        input bit [2:0] res, input bit push);
        bit got = 0;
        if (id) begin r1v = 1; r1a = a; r1b = b; end
        else    begin r0v = 1; r0a = a; r0b = b; end
        for (int n = 0; n < 50 && !got; n++) begin
            #1;
            if (id ? r1rdy : r0rdy) begin
                got = 1;
                chk("other_ready_low", id ? r0rdy : r1rdy, 0);
                if (push) sb.push_back('{id: id, res: res, t: cyc});
            end
            @(negedge clk);
        end
        if (!got) chk("grant_timeout", 0, 1);
        r0v = 0; r1v = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1);
    end

    initial begin
        r0v = 1; r1v = 1; b_r0v = 1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready0", r0rdy, 0);
        chk("rst_ready1", r1rdy, 0);
        chk("rst_b_ready0", b_r0rdy, 0);
        chk("rst_rsp_valid", rspv, 0);
        chk("rst_busy", bsy, 0);
        chk("rst_cmp_in1", ci1, 0);
        chk("rst_cmp_in2", ci2, 0);
        chk("rst_rsp_id", rspid, 0);
        chk("rst_rsp_res", rspres, 0);
        r0v = 0; r1v = 0; b_r0v = 0;
        @(negedge clk);
        rst_n = 1;

        // Single transfer, then operands held after the response.
        send(0, 2'b10, 2'b01, 3'b100, 1);
        repeat (3) @(negedge clk);
        chk("cmp_in1_hold", ci1, 2'b10);
        chk("cmp_in2_hold", ci2, 2'b01);
        send(1, 2'b01, 2'b11, 3'b001, 1);
        repeat (3) @(negedge clk);

        // Contested arbitration from reset: 0,1,0,1.
        do_reset();
        r0v = 1; r1v = 1; r0a = 2'b11; r0b = 2'b11; r1a = 2'b11; r1b = 2'b11;
        for (int k = 0; k < 4; k++) begin
            bit got = 0;
            bit eid = bit'(k % 2);
            for (int n = 0; n < 50 && !got; n++) begin
                #1;
                if (r0rdy || r1rdy) begin
                    got = 1;
                    chk("rr_ready0", r0rdy, !eid);
                    chk("rr_ready1", r1rdy, eid);
                    sb.push_back('{id: eid, res: 3'b010, t: cyc});
                end
                @(negedge clk);
            end
            if (!got) chk("rr_timeout", 0, 1);
        end
        r0v = 0; r1v = 0;
        repeat (3) @(negedge clk);

        // Pulse from req1 while busy, dropped before grant: no transfer.
        send(0, 2'b01, 2'b00, 3'b100, 1);
        r1v = 1; r1a = 2'b10; r1b = 2'b10;
        @(negedge clk);
        r1v = 0;
        repeat (4) @(negedge clk);
        #1;
        chk("dropped_req_busy", bsy, 0);

        // All 16 operand pairs from req0.
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                send(0, 2'(a), 2'(b), golden(2'(a), 2'(b)), 1);
        repeat (3) @(negedge clk);

        // Reset during SETTLE abandons the transaction.
        send(0, 2'b11, 2'b00, 3'b100, 0);
        #1;
        chk("settle_busy", bsy, 1);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        #1;
        chk("abort_busy", bsy, 0);
        chk("abort_rsp_valid", rspv, 0);
        repeat (4) @(negedge clk);
        #1;
        chk("abort_no_rsp", rspv, 0);

        // HOLD_CYCLES=3 with stalled consumer and a waiting requester.
        begin
            int t0 = -1;
            b_r1v = 1; b_r1a = 2'b00; b_r1b = 2'b11; b_rsprdy = 0;
            for (int n = 0; n < 20 && t0 < 0; n++) begin
                #1;
                if (b_r1rdy) t0 = cyc;
                @(negedge clk);
            end
            if (t0 < 0) chk("b_grant_timeout", 0, 1);
            b_r1v = 0;
            b_r0v = 1; b_r0a = 2'b10; b_r0b = 2'b10;
            while (cyc < t0 + 3) @(negedge clk);
            #1;
            chk("b_no_valid_early", b_rspv, 0);
            @(negedge clk);
            #1;
            chk("b_latency", cyc, t0 + 4);
            for (int n = 0; n < 5; n++) begin
                chk("b_rsp_valid", b_rspv, 1);
                chk("b_rsp_res", b_rspres, 3'b001);
                chk("b_rsp_id", b_rspid, 1);
                chk("b_no_ready", {b_r0rdy, b_r1rdy}, 0);
                @(negedge clk);
                #1;
            end
            chk("b_cmp_in1", b_ci1, 2'b00);
            chk("b_cmp_in2", b_ci2, 2'b11);
            b_rsprdy = 1;
            @(negedge clk);
            #1;
            chk("b_waiting_granted", b_r0rdy, 1);
            @(negedge clk);
            b_r0v = 0;
            repeat (6) @(negedge clk);
        end

`ifdef CMP_ARBITER_ONEHOT_CHECK_EN
        #1;
        chk("cmp_err_clear", cerr, 0);
        force_bad = 1;
        send(0, 2'b01, 2'b00, 3'b110, 1);
        repeat (3) @(negedge clk);
        force_bad = 0;
        #1;
        chk("cmp_err_set", cerr, 1);
        send(0, 2'b01, 2'b00, 3'b100, 1);
        repeat (4) @(negedge clk);
        #1;
        chk("cmp_err_sticky", cerr, 1);
        do_reset();
        #1;
        chk("cmp_err_reset", cerr, 0);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cmp_arbiter.md
CMP_ARBITER -- requirements
Module: cmp_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 1, comparator settle cycles per transaction; SHALL be legal from 1 to 15.
REQ-002 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n  input  1  reset, synchronous and active-low.
REQ-004 Port req0_valid  input  1  requester 0 has an operand pair.
REQ-005 Port req0_a  input  2  requester 0 operand A.
REQ-006 Port req0_b  input  2  requester 0 operand B.
REQ-007 Port req0_ready  output  1  requester 0 accepted this cycle.
REQ-008 Ports req1_valid/req1_a/req1_b/req1_ready SHALL mirror REQ-004..007 for requester 1.
REQ-009 Port cmp_in1  output  2  operand A driven to the shared 2-bit comparator.
REQ-010 Port cmp_in2  output  2  operand B driven to the shared comparator.
REQ-011 Port cmp_o1, cmp_o2, cmp_o3  input  1 each  comparator results: in1>in2, in1==in2, in1<in2.
REQ-012 Port rsp_valid  output  1  result available.
REQ-013 Port rsp_id  output  1  requester index owning the result.
REQ-014 Port rsp_res  output  3  captured {cmp_o1,cmp_o2,cmp_o3}.
REQ-015 Port rsp_ready  input  1  consumer accepts the result.
REQ-016 Port busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states SHALL be IDLE, SETTLE and RESP.
REQ-018 In IDLE, a request SHALL transfer when reqN_valid and reqN_ready are both high in the same cycle.
REQ-019 reqN_ready SHALL be combinational, high only in IDLE for the granted requester, and at most one ready high per cycle.
REQ-020 Grant: single valid requester wins; if both valid, the requester not granted last wins (round-robin); no valid means no grant.
REQ-021 On transfer, operands, requester index and the last-grant pointer SHALL be registered, and the FSM SHALL go to SETTLE.
REQ-022 cmp_in1/cmp_in2 SHALL equal the registered operands and SHALL hold them through SETTLE and RESP until the next transfer.
REQ-023 SETTLE SHALL last exactly HOLD_CYCLES cycles, counted by a 4-bit down-counter.
REQ-024 In the last SETTLE cycle, {cmp_o1,cmp_o2,cmp_o3} SHALL be captured into rsp_res, and the FSM SHALL go to RESP.
REQ-025 Latency: for a transfer in cycle T, rsp_valid SHALL first be high in cycle T+HOLD_CYCLES+1.
REQ-026 In RESP, rsp_valid SHALL be high, and rsp_id/rsp_res SHALL be stable until rsp_ready is sampled high.
REQ-027 The cycle rsp_ready is high in RESP SHALL return the FSM to IDLE; the earliest next transfer is the following cycle.
REQ-028 A request arriving while not in IDLE SHALL wait with no ready; no request SHALL be dropped or duplicated.
REQ-029 rsp_ready outside RESP SHALL be ignored.
REQ-030 A requester dropping valid before grant SHALL cause no transfer.

Reset
REQ-031 rst_n low at a clock edge SHALL, in any state, force IDLE and abandon any in-flight transaction without a response.
REQ-032 Reset values SHALL be: rsp_valid=0, rsp_id=0, rsp_res=3'b000, cmp_in1=cmp_in2=2'b00, busy=0, counter=0.
REQ-033 The last-grant pointer SHALL reset to 1, so requester 0 wins the first contested arbitration.
REQ-034 During reset, both reqN_ready SHALL be 0.

Configuration
REQ-035 With macro CMP_ARBITER_ONEHOT_CHECK_EN defined, output port cmp_err (1 bit) SHALL exist.
REQ-036 cmp_err SHALL set when a captured result is not one-hot, SHALL stay set until reset, and SHALL reset to 0.
REQ-037 Without CMP_ARBITER_ONEHOT_CHECK_EN, port cmp_err and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-038 HOLD_CYCLES=1, req0 a=2'b10 b=2'b01 accepted in cycle T, rsp_ready=1 -> rsp_valid high in T+2, rsp_id=0, rsp_res=3'b100.
REQ-039 Both valid continuously after reset with a=b=2'b11 -> grants alternate 0,1,0,1, and each rsp_res=3'b010.
REQ-040 HOLD_CYCLES=3, req1 a=2'b00 b=2'b11, rsp_ready held 0 for 5 cycles -> rsp_valid at T+4, rsp_res=3'b001 stable and no ready pulses until handshake.
REQ-041 rst_n low during SETTLE -> next cycle IDLE, busy=0, and no rsp_valid for that transaction.
REQ-042 With CMP_ARBITER_ONEHOT_CHECK_EN, comparator model forcing 3'b110 -> cmp_err=1 persisting until rst_n low.
REQ-043 All 16 operand pairs from req0 -> each rsp_res matches the a>b/a==b/a<b golden model.
